// File: rtl/k_sync_fifo_param.sv
// rtl/k_sync_fifo_param.sv - parametrised single-clock FIFO with registered read data
// Optional sticky overflow/underflow flags are built when K_FIFO_ERR_FLAGS_EN is defined.
module k_sync_fifo_param #(
   parameter int data_size   = 8,
   parameter int addr_size   = 2,
   parameter int afull_level = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [data_size-1:0] d,
   input  logic                 wen,
   input  logic                 ren,
   output logic [data_size-1:0] q,
   output logic                 full,
   output logic                 empty,
   output logic                 afull,
   output logic [addr_size:0]   count,
   output logic                 overflow,
   output logic                 underflow
);
   localparam int depth = 1 << addr_size;
   localparam logic [addr_size:0] afull_thr = (addr_size + 1)'(afull_level);
   localparam logic [addr_size:0] one = (addr_size + 1)'(1);

   logic [data_size-1:0] mem [depth];
   logic [addr_size:0]   wptr;
   logic [addr_size:0]   rptr;
   logic [addr_size:0]   cnt;
   logic                 rd_ok;
   logic                 wr_ok;

   // The extra pointer MSB distinguishes a full ring from an empty one.
   assign empty = (wptr == rptr);
   assign full  = (wptr[addr_size] != rptr[addr_size]) &&
                  (wptr[addr_size-1:0] == rptr[addr_size-1:0]);
   assign afull = (cnt >= afull_thr);
   assign count = cnt;

   // A read frees a slot in the same cycle, so a full FIFO still accepts wen&ren.
   assign rd_ok = ren & ~empty;
   assign wr_ok = wen & (~full | rd_ok);

   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wptr[addr_size-1:0]] <= d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         q    <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + one;
         end
         if (rd_ok) begin
            rptr <= rptr + one;
            q    <= mem[rptr[addr_size-1:0]];
         end
         case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + one;
            2'b01:   cnt <= cnt - one;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef K_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wen && full && !rd_ok) begin
            overflow <= 1'b1;
         end
         if (ren && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_k_sync_fifo_param.sv
// tb/tb_k_sync_fifo_param.sv - queue-model checking bench for k_sync_fifo_param
// Honours K_FIFO_ERR_FLAGS_EN for the expected overflow/underflow behaviour.
module tb_k_sync_fifo_param;
   localparam int dw = 8;
   localparam int aw = 2;
   localparam int depth = 4;
   localparam int alvl = 3;
`ifdef K_FIFO_ERR_FLAGS_EN
   localparam bit err_en = 1'b1;
`else
   localparam bit err_en = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [dw-1:0] d = '0;
   logic          wen = 1'b0;
   logic          ren = 1'b0;
   logic [dw-1:0] q;
   logic          full, empty, afull, overflow, underflow;
   logic [aw:0]   count;

   k_sync_fifo_param #(.data_size(dw), .addr_size(aw), .afull_level(alvl)) dut (
      .clk(clk), .rst(rst), .d(d), .wen(wen), .ren(ren), .q(q),
      .full(full), .empty(empty), .afull(afull), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   bit checking = 1'b0;

   logic [dw-1:0] mq[$];
   logic [dw-1:0] m_q = '0;
   bit m_ov = 1'b0;
   bit m_un = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model advances on the same edge as the DUT, using the inputs applied before it.
   task automatic cyc(input bit r, input bit w, input bit rd, input logic [dw-1:0] data);
      bit m_empty, m_full, rd_ok, wr_ok;
      rst = r; wen = w; ren = rd; d = data;
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_q = '0; m_ov = 1'b0; m_un = 1'b0;
      end else begin
         m_empty = (mq.size() == 0);
         m_full  = (mq.size() == depth);
         rd_ok = rd && !m_empty;
         wr_ok = w && (!m_full || rd_ok);
         if (err_en && w && m_full && !rd_ok) m_ov = 1'b1;
         if (err_en && rd && m_empty) m_un = 1'b1;
         if (rd_ok) m_q = mq.pop_front();
         if (wr_ok) mq.push_back(data);
      end
      checking = 1'b1;
      @(negedge clk);
      rst = 1'b0; wen = 1'b0; ren = 1'b0;
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("q", q, m_q);
         chk("count", count, mq.size());
         chk("empty", empty, mq.size() == 0);
         chk("full", full, mq.size() == depth);
         chk("afull", afull, mq.size() >= alvl);
         chk("overflow", overflow, m_ov);
         chk("underflow", underflow, m_un);
      end
   end

   initial begin
      cyc(1, 0, 0, 8'h00);
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 0, 8'h00);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_q", q, 8'h00);
      chk("rst_full", full, 0);

      cyc(0, 1, 0, 8'hA1);
      cyc(0, 1, 0, 8'hA2);
      chk("afull_at2", afull, 0);
      cyc(0, 1, 0, 8'hA3);
      chk("afull_at3", afull, 1);
      cyc(0, 1, 0, 8'hA4);
      chk("full_at4", full, 1);
      cyc(0, 1, 0, 8'hFF);
      chk("ovf_count", count, 4);
      chk("ovf_flag", overflow, err_en);

      cyc(0, 0, 1, 8'h00); chk("rd1", q, 8'hA1);
      cyc(0, 0, 1, 8'h00); chk("rd2", q, 8'hA2);
      cyc(0, 0, 1, 8'h00); chk("rd3", q, 8'hA3);
      cyc(0, 0, 1, 8'h00); chk("rd4", q, 8'hA4);
      chk("empty_after", empty, 1);
      cyc(0, 0, 1, 8'h00);
      chk("udf_q", q, 8'hA4);
      chk("udf_flag", underflow, err_en);

      cyc(0, 1, 0, 8'h10);
      cyc(0, 1, 0, 8'h11);
      for (int i = 2; i < 10; i++) begin
         cyc(0, 1, 1, 8'h10 + 8'(i));
         chk("wrap_q", q, 8'h10 + 8'(i - 2));
         chk("wrap_count", count, 2);
      end
      cyc(0, 0, 1, 8'h00); chk("wrap_tail1", q, 8'h18);
      cyc(0, 0, 1, 8'h00); chk("wrap_tail2", q, 8'h19);

      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h20 + 8'(i));
      cyc(0, 1, 1, 8'hB5);
      chk("fullrw_q", q, 8'h20);
      chk("fullrw_count", count, 4);
      chk("fullrw_full", full, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'h00);
      chk("drain_last", q, 8'hB5);

      cyc(0, 1, 1, 8'hC7);
      chk("emptyrw_q", q, 8'hB5);
      chk("emptyrw_count", count, 1);
      chk("emptyrw_empty", empty, 0);
      cyc(0, 0, 1, 8'h00);
      chk("emptyrw_rd", q, 8'hC7);

      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h31 + 8'(i));
      chk("pre_rst_count", count, 3);
      cyc(1, 1, 1, 8'hEE);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_q", q, 8'h00);
      chk("mid_rst_ovf", overflow, 0);
      cyc(0, 1, 0, 8'h5A);
      cyc(0, 0, 1, 8'h00);
      chk("post_rst_q", q, 8'h5A);
      cyc(0, 0, 0, 8'h00);

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
